// File: rtl/uvmt_i2c_st_byte_ctlr.sv
// Byte-level I2C controller engine: START / WRITE / READ / STOP sequencing with
// open-drain SCL/SDA enables, quarter-period prescaler and target clock stretching.
module uvmt_i2c_st_byte_ctlr #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_ack,
    output logic       rsp_err,
    output logic       busy,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_START = 3'd2,
        ST_BIT   = 3'd3,
        ST_STOP  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [3:0]       bit_q, bit_d;
    logic             rd_q, rd_d;
    logic             nack_q, nack_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             scl_oe_q, scl_oe_d;
    logic             sda_oe_q, sda_oe_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_ack_q, rsp_ack_d;
    logic             rsp_err_q, rsp_err_d;

    logic accept_s;
    logic stall_s;
    logic qtr_end_s;
    logic timed_s;

    // SDA pull-down for a bit slot: data bits MSB first for WRITE, ACK/NACK on slot 8 for READ
    function automatic logic bit_drive(input logic rd, input logic nack,
                                       input logic [7:0] tx, input logic [3:0] idx);
        logic [2:0] pos;
        pos = 3'(4'd7 - idx);
        if (idx == 4'd8) begin
            return rd ? ~nack : 1'b0;
        end else if (rd) begin
            return 1'b0;
        end else begin
            return ~tx[pos];
        end
    endfunction

    assign cmd_ready = ~reset & ((state_q == ST_IDLE) | (state_q == ST_HOLD));
    assign busy      = (state_q != ST_IDLE) & (state_q != ST_HOLD);
    assign accept_s  = cmd_valid & cmd_ready;
    // A released SCL that still reads low is the target stretching the clock
    assign stall_s   = ~scl_oe_q & ~scl_i;
    assign qtr_end_s = (cnt_q == CNT_LAST) & ~stall_s;
    assign timed_s   = (state_q == ST_START) | (state_q == ST_BIT) | (state_q == ST_STOP);

    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ack   = rsp_ack_q;
    assign rsp_err   = rsp_err_q;

    // Next-state, prescaler and next-output computation
    always_comb begin
        state_d     = state_q;
        qtr_d       = qtr_q;
        bit_d       = bit_q;
        rd_d        = rd_q;
        nack_d      = nack_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        scl_oe_d    = scl_oe_q;
        sda_oe_d    = sda_oe_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = 8'h00;
        rsp_ack_d   = 1'b0;
        rsp_err_d   = 1'b0;

        if (timed_s && !qtr_end_s) begin
            cnt_d = stall_s ? cnt_q : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept_s) begin
                    qtr_d = 2'd0;
                    bit_d = 4'd0;
                    case (cmd_op)
                        OP_START: begin
                            state_d  = ST_START;
                            scl_oe_d = 1'b0;
                            sda_oe_d = 1'b0;
                        end
                        OP_WRITE, OP_READ: begin
                            if (state_q == ST_IDLE) begin
                                state_d     = ST_ERR;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                            end else begin
                                state_d  = ST_BIT;
                                rd_d     = (cmd_op == OP_READ);
                                tx_d     = cmd_data;
                                nack_d   = cmd_nack;
                                rx_d     = 8'h00;
                                scl_oe_d = 1'b1;
                                sda_oe_d = bit_drive(cmd_op == OP_READ, cmd_nack, cmd_data, 4'd0);
                            end
                        end
                        OP_STOP: begin
                            if (state_q == ST_IDLE) begin
                                state_d     = ST_ERR;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                            end else begin
                                state_d  = ST_STOP;
                                scl_oe_d = 1'b1;
                                sda_oe_d = 1'b1;
                            end
                        end
                        default: begin
                            state_d = state_q;
                        end
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_START: begin
                if (qtr_end_s) begin
                    if (qtr_q == 2'd3) begin
                        state_d  = ST_HOLD;
                        scl_oe_d = 1'b1;
                    end else begin
                        qtr_d    = qtr_q + 2'd1;
                        sda_oe_d = (qtr_q >= 2'd1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_BIT: begin
                if (qtr_end_s) begin
                    case (qtr_q)
                        2'd0: qtr_d = 2'd1;
                        2'd1: begin
                            qtr_d    = 2'd2;
                            scl_oe_d = 1'b0;
                        end
                        2'd2: qtr_d = 2'd3;
                        default: begin
                            // Last cycle of Q3: SDA is sampled here
                            if (bit_q == 4'd8) begin
                                state_d     = ST_HOLD;
                                scl_oe_d    = 1'b1;
                                sda_oe_d    = 1'b0;
                                rsp_valid_d = 1'b1;
                                rsp_data_d  = rd_q ? rx_q : 8'h00;
                                rsp_ack_d   = sda_i;
                            end else begin
                                rx_d     = {rx_q[6:0], sda_i};
                                bit_d    = bit_q + 4'd1;
                                qtr_d    = 2'd0;
                                scl_oe_d = 1'b1;
                                sda_oe_d = bit_drive(rd_q, nack_q, tx_q, bit_q + 4'd1);
                            end
                        end
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_STOP: begin
                if (qtr_end_s) begin
                    case (qtr_q)
                        2'd0: begin
                            qtr_d    = 2'd1;
                            scl_oe_d = 1'b0;
                        end
                        2'd1: qtr_d = 2'd2;
                        2'd2: begin
                            qtr_d    = 2'd3;
                            sda_oe_d = 1'b0;
                        end
                        default: begin
                            state_d  = ST_IDLE;
                            scl_oe_d = 1'b0;
                            sda_oe_d = 1'b0;
                        end
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs, synchronous reset releases the bus
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            qtr_q       <= 2'd0;
            bit_q       <= 4'd0;
            rd_q        <= 1'b0;
            nack_q      <= 1'b0;
            tx_q        <= 8'h00;
            rx_q        <= 8'h00;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_ack_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            rd_q        <= rd_d;
            nack_q      <= nack_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ack_q   <= rsp_ack_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_uvmt_i2c_st_byte_ctlr.sv
// Self-checking bench for uvmt_i2c_st_byte_ctlr: directed command sequence with random
// bytes/ACKs/stretch, a behavioural I2C target and wire-level bus monitor.
module tb_uvmt_i2c_st_byte_ctlr;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_nack;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ack;
    logic       rsp_err;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_w;
    logic       sda_w;

    logic       tgt_scl_hold = 1'b0;
    logic       tgt_active = 1'b0;
    logic [8:0] tgt_pat = 9'h1FF;
    int         tgt_base = 0;
    int         tgt_idx;
    logic       tgt_sda_low;

    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         fall_cnt = 0;
    int         rise_cnt = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         rsp_cnt = 0;
    logic [8:0] oe_cap = 9'h000;

    int n_checks = 0;
    int n_fail = 0;

    uvmt_i2c_st_byte_ctlr #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_nack(cmd_nack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ack(rsp_ack), .rsp_err(rsp_err),
        .busy(busy), .scl_i(scl_w), .sda_i(sda_w), .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    assign scl_w = ~(scl_oe | tgt_scl_hold);
    assign sda_w = ~(sda_oe | tgt_sda_low);

    // Target: presents pattern bit k after the k-th SCL fall since it was armed
    always_comb begin
        tgt_idx     = fall_cnt - tgt_base;
        tgt_sda_low = 1'b0;
        if (tgt_active && tgt_idx >= 0 && tgt_idx < 9) begin
            tgt_sda_low = ~tgt_pat[8 - tgt_idx];
        end
    end

    // Bus monitor: SCL edges, START/STOP conditions, controller SDA drive at SCL rise
    always @(posedge clk) begin
        prev_scl <= scl_w;
        prev_sda <= sda_w;
        if (prev_scl === 1'b1 && scl_w === 1'b0) fall_cnt <= fall_cnt + 1;
        if (prev_scl === 1'b0 && scl_w === 1'b1) begin
            rise_cnt <= rise_cnt + 1;
            oe_cap   <= {oe_cap[7:0], sda_oe};
        end
        if (prev_scl === 1'b1 && scl_w === 1'b1 && prev_sda === 1'b1 && sda_w === 1'b0) start_cnt <= start_cnt + 1;
        if (prev_scl === 1'b1 && scl_w === 1'b1 && prev_sda === 1'b0 && sda_w === 1'b1) stop_cnt <= stop_cnt + 1;
        if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic nack);
        @(negedge clk);
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_nack  = nack;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (cmd_ready === 1'b1) break;
        end
    endtask

    task automatic do_start();
        int n;
        int s0;
        s0 = start_cnt;
        issue(2'd0, 8'h00, 1'b0);
        chk("start_busy", busy, 1);
        wait_ready(n);
        chk("start_latency", n, 4 * CLK_DIV);
        chk("start_scl_oe", scl_oe, 1);
        chk("start_sda_oe", sda_oe, 1);
        chk("start_busy_done", busy, 0);
        chk("start_condition", start_cnt - s0, 1);
    endtask

    task automatic do_stop();
        int n;
        int s0;
        s0 = stop_cnt;
        issue(2'd3, 8'h00, 1'b0);
        wait_ready(n);
        chk("stop_latency", n, 4 * CLK_DIV);
        chk("stop_scl_oe", scl_oe, 0);
        chk("stop_sda_oe", sda_oe, 0);
        chk("stop_busy", busy, 0);
        chk("stop_condition", stop_cnt - s0, 1);
    endtask

    // rd=0: WRITE data, target answers ack_nack; rd=1: READ, target sends data, ack_nack is cmd_nack
    task automatic do_byte(input logic rd, input logic [7:0] data, input logic ack_nack, input int stretch);
        int n;
        int r0;
        int c0;
        logic got;
        logic [8:0] exp_oe;
        repeat (2) @(posedge clk);
        #1;
        tgt_pat    = rd ? {data, 1'b1} : {8'hFF, ack_nack};
        tgt_base   = fall_cnt;
        tgt_active = 1'b1;
        r0 = rise_cnt;
        c0 = rsp_cnt;
        issue(rd ? 2'd2 : 2'd1, data, rd ? ack_nack : 1'b0);
        n = 0;
        got = 1'b0;
        while (!got && n < 600) begin
            @(posedge clk);
            #1;
            n++;
            if (stretch > 0 && n == 50) tgt_scl_hold = 1'b1;
            if (n == 56 + stretch) tgt_scl_hold = 1'b0;
            if (rsp_valid === 1'b1) got = 1'b1;
        end
        tgt_scl_hold = 1'b0;
        exp_oe = rd ? {8'h00, ~ack_nack} : {~data, 1'b0};
        chk("byte_latency", n, 36 * CLK_DIV + stretch);
        chk("byte_rsp_err", rsp_err, 0);
        chk("byte_rsp_data", rsp_data, rd ? data : 8'h00);
        chk("byte_rsp_ack", rsp_ack, ack_nack);
        chk("byte_hold_scl_oe", scl_oe, 1);
        chk("byte_hold_sda_oe", sda_oe, 0);
        @(posedge clk);
        #1;
        chk("byte_rsp_pulse_end", rsp_valid, 0);
        chk("byte_scl_pulses", rise_cnt - r0, 9);
        chk("byte_sda_pattern", oe_cap, exp_oe);
        chk("byte_rsp_count", rsp_cnt - c0, 1);
        tgt_active = 1'b0;
    endtask

    initial begin
        int c0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = 8'h00;
        cmd_nack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_release_ready", cmd_ready, 1);

        // WRITE, READ and STOP are illegal while the bus is idle
        for (int op = 1; op < 4; op++) begin
            issue(2'(op), 8'($urandom_range(0, 255)), 1'b0);
            chk("err_rsp_valid", rsp_valid, 1);
            chk("err_rsp_err", rsp_err, 1);
            chk("err_rsp_ack", rsp_ack, 0);
            chk("err_rsp_data", rsp_data, 0);
            chk("err_scl_oe", scl_oe, 0);
            chk("err_sda_oe", sda_oe, 0);
            chk("err_ready_low", cmd_ready, 0);
            @(posedge clk);
            #1;
            chk("err_ready_back", cmd_ready, 1);
            chk("err_rsp_end", rsp_valid, 0);
            chk("err_bus_idle", scl_oe | sda_oe, 0);
        end

        do_start();
        do_byte(1'b0, 8'hA5, 1'b0, 0);
        do_byte(1'b0, 8'($urandom_range(0, 255)), 1'b1, 10);
        do_start();
        do_byte(1'b1, 8'h3C, 1'b1, 0);
        do_byte(1'b1, 8'($urandom_range(0, 255)), 1'b0, int'($urandom_range(1, 12)));
        do_byte(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);
        do_stop();

        // Reset in the middle of bit 5 of a READ
        do_start();
        repeat (2) @(posedge clk);
        #1;
        tgt_pat    = {8'($urandom_range(0, 255)), 1'b1};
        tgt_base   = fall_cnt;
        tgt_active = 1'b1;
        issue(2'd2, 8'h00, 1'b0);
        repeat (86) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        tgt_active = 1'b0;
        chk("midrst_scl_oe", scl_oe, 0);
        chk("midrst_sda_oe", sda_oe, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_ready", cmd_ready, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        c0 = rsp_cnt;
        repeat (200) @(posedge clk);
        #1;
        chk("midrst_no_rsp", rsp_cnt - c0, 0);
        chk("midrst_bus_idle", scl_oe | sda_oe, 0);
        do_start();
        do_stop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uvmt_i2c_st_byte_ctlr.md
Name: uvmt_i2c_st_byte_ctlr

Overview:
Byte-level I2C controller engine that sequences the self-test controller-side bus.
- Accepts START / WRITE / READ / STOP commands over a valid/ready port.
- Produces open-drain SCL/SDA enables from a quarter-period prescaler, honouring target clock stretching.
- Returns per-byte responses (read data, ACK/NACK, error).
- Sits between the self-test stimulus logic and the shared I2C wires monitored by the controller, target and passive agents.

Parameters:
- CLK_DIV, 4: clk cycles per SCL quarter-period; legal range >= 2. Prescaler counter width is $clog2(CLK_DIV).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  engine can accept a command
- cmd_op  in  2  0=START (repeated start when bus held), 1=WRITE, 2=READ, 3=STOP
- cmd_data  in  8  byte to transmit (WRITE)
- cmd_nack  in  1  READ only: 1 = release SDA on the 9th bit (NACK), 0 = drive ACK
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_data  out  8  received byte (READ); 0 otherwise
- rsp_ack  out  1  SDA sampled on the 9th bit (WRITE: 0=ACK); 0 otherwise
- rsp_err  out  1  command illegal in current state
- busy  out  1  engine is not in IDLE or HOLD
- scl_i  in  1  SCL wire level
- sda_i  in  1  SDA wire level
- scl_oe  out  1  1 = pull SCL low
- sda_oe  out  1  1 = pull SDA low

Behaviour:
- Reset (synchronous, active-high): state=IDLE; scl_oe, sda_oe, rsp_*, busy=0; cmd_ready=0 while reset is asserted, 1 on the first cycle after deassertion.
- Reset mid-operation: the bus is released (scl_oe=sda_oe=0) on the cycle after reset is sampled; no rsp_valid is generated.
- States: IDLE (bus free, both lines released), HOLD (after START/byte: scl_oe=1, sda_oe keeps its last value), START, BIT, STOP, ERR.
- cmd_ready=1 only in IDLE or HOLD. A command is accepted on cmd_valid & cmd_ready; the engine leaves IDLE/HOLD on the next cycle.
- Quarter timing: each phase lasts CLK_DIV cycles.
  - In any quarter where SCL is released, the prescaler does not count while scl_i==0 (clock stretch). The quarter length extends by exactly the number of stretched cycles.
- START (from IDLE or HOLD):
  - Q0: SCL released, SDA released (stretch applies).
  - Q1: SDA released.
  - Q2: sda_oe=1.
  - Q3: sda_oe=1.
  - Then scl_oe=1 -> HOLD.
- BIT (9 bits, MSB first for WRITE; bit 9 is ACK):
  - Q0: scl_oe=1, set sda_oe (WRITE: ~data bit; READ: 0; READ bit 9: ~cmd_nack; WRITE bit 9: 0).
  - Q1: scl_oe=1.
  - Q2: SCL released (stretch applies).
  - Q3: SCL released; sda_i is sampled on the last cycle of Q3.
- After bit 9 -> HOLD with scl_oe=1, sda_oe=0. rsp_valid pulses on the first cycle in HOLD.
  - WRITE: rsp_ack = bit-9 sample.
  - READ: rsp_data = bits 1-8 samples; rsp_ack = bit-9 sample.
- STOP (from HOLD):
  - Q0: scl_oe=1, sda_oe=1.
  - Q1: SCL released, sda_oe=1 (stretch applies).
  - Q2: sda_oe=1.
  - Q3: sda_oe=0.
  - Then IDLE; no response.
- Unstretched latency, command accept to HOLD/IDLE entry:
  - START/STOP: 4*CLK_DIV cycles.
  - WRITE/READ: 36*CLK_DIV cycles.
- Illegal commands (WRITE, READ or STOP while IDLE): accepted; go to ERR for one cycle with rsp_valid=1, rsp_err=1, no bus activity, then back to IDLE.
- rsp_err=0 on every legal response.
- The engine does not detect arbitration loss; SDA mismatch during WRITE is ignored.

Test Plan:
- CLK_DIV=4, START from IDLE -> cmd_ready low for 16 cycles; sda_oe rises while SCL released; scl_oe=1 and state HOLD at cycle 16.
- START, then WRITE 0xA5 with target ACK -> scl_oe toggles 9 times; sda_oe pattern matches ~1010_0101; rsp_valid pulses once 144 cycles after accept with rsp_ack=0, rsp_err=0.
- START, then READ cmd_nack=1 with target driving 0x3C -> rsp_data=0x3C, rsp_ack=1, sda_oe=0 throughout bit 9; then STOP -> SDA released while SCL high; IDLE.
- Target holds scl_i low for 10 cycles in bit 3 Q2 of a WRITE -> byte latency is 154 cycles and no quarter is shortened.
- WRITE in IDLE -> rsp_valid=1, rsp_err=1 on the cycle after accept; scl_oe=sda_oe=0 throughout; cmd_ready back to 1 next cycle.
- Assert reset during bit 5 of a READ -> scl_oe=sda_oe=0 on the next cycle, no rsp_valid; after deassert, START completes normally.
